// File: rtl/param_register_file_pkg.sv
// Shared definitions for the parameterised register bank.
//  - FS_* : 4-bit function-select codes applied by every enabled register.
//  - sext8: sign-extends an 8-bit value; callers size-cast the result to
//           their own register width.
package param_register_file_pkg;

  localparam logic [3:0] FS_DEC  = 4'd0;
  localparam logic [3:0] FS_INC  = 4'd1;
  localparam logic [3:0] FS_LOAD = 4'd2;
  localparam logic [3:0] FS_CLR  = 4'd3;
  localparam logic [3:0] FS_LDLZ = 4'd4;
  localparam logic [3:0] FS_WRLO = 4'd5;
  localparam logic [3:0] FS_WRHI = 4'd6;
  localparam logic [3:0] FS_LDLS = 4'd7;
  localparam logic [3:0] FS_SHL  = 4'd8;
  localparam logic [3:0] FS_SHR  = 4'd9;
  localparam logic [3:0] FS_ASR  = 4'd10;
  localparam logic [3:0] FS_ROL  = 4'd11;
  localparam logic [3:0] FS_ROR  = 4'd12;
  localparam logic [3:0] FS_SWAP = 4'd13;

  // Widest register the sign-extension helper can serve.
  localparam int SEXT_MAX_W = 256;

  function automatic logic [SEXT_MAX_W-1:0] sext8(input logic [7:0] i_b);
    return {{(SEXT_MAX_W-8){i_b[7]}}, i_b};
  endfunction

endpackage

// File: rtl/param_register_file_reg_slice.sv
// One WIDTH-bit register with its carry/shift-out flag and op decode.
// Ports:
//  Clock   in  rising-edge clock
//  Reset   in  asynchronous active-low reset (register = RESET_VAL, carry = 0)
//  i_en    in  this register executes i_fun on the next edge
//  i_fun   in  4-bit function select
//  i_data  in  write data
//  o_q     out current register value
//  o_c     out current carry/borrow/shift-out flag
module reg_slice
  import param_register_file_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_en,
  input  logic [3:0]       i_fun,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_q,
  output logic             o_c
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_c;
  logic [WIDTH-1:0] w_nq;
  logic             w_nc;

  // Next state defaults to hold, which also covers the reserved codes 14/15.
  always_comb begin
    w_nq = r_q;
    w_nc = r_c;
    case (i_fun)
      FS_DEC: begin
        w_nq = r_q - ONE;
        w_nc = (r_q == '0);
      end
      FS_INC: begin
        w_nq = r_q + ONE;
        w_nc = &r_q;
      end
      FS_LOAD: begin
        w_nq = i_data;
        w_nc = 1'b0;
      end
      FS_CLR: begin
        w_nq = '0;
        w_nc = 1'b0;
      end
      FS_LDLZ: begin
        w_nq      = '0;
        w_nq[7:0] = i_data[7:0];
        w_nc      = 1'b0;
      end
      FS_WRLO: w_nq[7:0]  = i_data[7:0];
      FS_WRHI: w_nq[15:8] = i_data[7:0];
      FS_LDLS: begin
        w_nq = WIDTH'(sext8(i_data[7:0]));
        w_nc = 1'b0;
      end
      FS_SHL: begin
        w_nq = {r_q[WIDTH-2:0], 1'b0};
        w_nc = r_q[WIDTH-1];
      end
      FS_SHR: begin
        w_nq = {1'b0, r_q[WIDTH-1:1]};
        w_nc = r_q[0];
      end
      FS_ASR: begin
        w_nq = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_nc = r_q[0];
      end
      FS_ROL: begin
        w_nq = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_nc = r_q[WIDTH-1];
      end
      FS_ROR: begin
        w_nq = {r_q[0], r_q[WIDTH-1:1]};
        w_nc = r_q[0];
      end
      // Byte lanes are fixed at [15:8]/[7:0]; any wider bits stay put.
      FS_SWAP: begin
        w_nq[15:8] = r_q[7:0];
        w_nq[7:0]  = r_q[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_q <= RESET_VAL;
      r_c <= 1'b0;
    end else if (i_en) begin
      r_q <= w_nq;
      r_c <= w_nc;
    end
  end

  assign o_q = r_q;
  assign o_c = r_c;

endmodule

// File: rtl/param_register_file.sv
// Bank of NUM_REGS registers sharing one function select, with per-register
// enables (multi-hot allowed) and two combinational read ports.
// Ports:
//  Clock    in  rising-edge clock
//  Reset    in  asynchronous active-low reset, clears the bank
//  I        in  write data
//  RegSel   in  per-register enable mask
//  FunSel   in  operation code applied by every enabled register
//  OutASel  in  read index, port A
//  OutBSel  in  read index, port B
//  OutA     out contents of register OutASel (0 when out of range)
//  OutB     out contents of register OutBSel (0 when out of range)
//  Carry    out per-register carry/borrow/shift-out flags
module param_register_file
  import param_register_file_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               NUM_REGS  = 4,
  parameter int               SEL_W     = $clog2(NUM_REGS),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [WIDTH-1:0]    I,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [3:0]          FunSel,
  input  logic [SEL_W-1:0]    OutASel,
  input  logic [SEL_W-1:0]    OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic [NUM_REGS-1:0] Carry
);

  logic [WIDTH-1:0] w_q [NUM_REGS];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    reg_slice #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_slice (
      .Clock  (Clock),
      .Reset  (Reset),
      .i_en   (RegSel[k]),
      .i_fun  (FunSel),
      .i_data (I),
      .o_q    (w_q[k]),
      .o_c    (Carry[k])
    );
  end

  // Matching only the valid indices leaves unused codes (non power-of-2
  // bank sizes) at the zero default.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (OutASel == SEL_W'(k)) OutA = w_q[k];
      if (OutBSel == SEL_W'(k)) OutB = w_q[k];
    end
  end

endmodule
